// File: rtl/bcd_counter_scan_src.sv
// 4-digit BCD up/down counter stepped by a prescaled tick, plus a free-running 2-bit scan select.
// Define BCD_CNT_LOAD_EN to add the synchronous parallel load ports (load, load_val).
module bcd_counter_scan_src #(
   parameter int COUNT_DIV     = 100_000_000,
   parameter int SCAN_DIV_BITS = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        up,
   input  logic        clr,
`ifdef BCD_CNT_LOAD_EN
   input  logic        load,
   input  logic [15:0] load_val,
`endif
   output logic [3:0]  bcd3,
   output logic [3:0]  bcd2,
   output logic [3:0]  bcd1,
   output logic [3:0]  bcd0,
   output logic [1:0]  scan_sel,
   output logic        tick,
   output logic        wrap
);

   localparam int PRE_W = $clog2(COUNT_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(COUNT_DIV - 1);

   logic [PRE_W-1:0]         pre;
   logic [SCAN_DIV_BITS-1:0] scan_div;
   logic [3:0]               digit     [4];
   logic [3:0]               digit_nxt [4];
   logic                     step_wrap;

`ifdef BCD_CNT_LOAD_EN
   function automatic logic [3:0] clamp9(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction
`endif

   // Ripple the carry (up) or borrow (down) from the units digit; surviving past the top means wrap.
   always_comb begin
      logic carry;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         digit_nxt[i] = digit[i];
         if (up) begin
            if (carry) digit_nxt[i] = (digit[i] == 4'd9) ? 4'd0 : digit[i] + 4'd1;
            carry = carry && (digit[i] == 4'd9);
         end else begin
            if (carry) digit_nxt[i] = (digit[i] == 4'd0) ? 4'd9 : digit[i] - 4'd1;
            carry = carry && (digit[i] == 4'd0);
         end
      end
      step_wrap = carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scan_div <= '0;
      else        scan_div <= scan_div + SCAN_DIV_BITS'(1);
   end

   assign scan_sel = scan_div[SCAN_DIV_BITS-1 -: 2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre   <= '0;
         digit <= '{default: 4'd0};
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (clr) begin
            pre   <= '0;
            digit <= '{default: 4'd0};
`ifdef BCD_CNT_LOAD_EN
         end else if (load) begin
            pre      <= '0;
            digit[3] <= clamp9(load_val[15:12]);
            digit[2] <= clamp9(load_val[11:8]);
            digit[1] <= clamp9(load_val[7:4]);
            digit[0] <= clamp9(load_val[3:0]);
`endif
         end else if (en) begin
            if (pre == PRE_MAX) begin
               pre   <= '0;
               digit <= digit_nxt;
               tick  <= 1'b1;
               wrap  <= step_wrap;
            end else begin
               pre <= pre + PRE_W'(1);
            end
         end
      end
   end

   assign bcd3 = digit[3];
   assign bcd2 = digit[2];
   assign bcd1 = digit[1];
   assign bcd0 = digit[0];

endmodule

// File: tb/tb_bcd_counter_scan_src.sv
// Scoreboard bench for bcd_counter_scan_src (COUNT_DIV=4, SCAN_DIV_BITS=3); expected steps are
// queued with the cycle they must appear on, and a negedge monitor pops them on every tick.
module tb_bcd_counter_scan_src;

   localparam int COUNT_DIV     = 4;
   localparam int SCAN_DIV_BITS = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        up;
   logic        clr;
`ifdef BCD_CNT_LOAD_EN
   logic        load;
   logic [15:0] loadVal;
`endif
   logic [3:0]  bcd3, bcd2, bcd1, bcd0;
   logic [1:0]  scanSel;
   logic        tick;
   logic        wrap;
   logic [15:0] digits;

   int total = 0;
   int bad = 0;
   int edgeCount = 0;

   typedef struct {
      logic [15:0] digits;
      logic        wrap;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   bcd_counter_scan_src #(
      .COUNT_DIV     (COUNT_DIV),
      .SCAN_DIV_BITS (SCAN_DIV_BITS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .clr      (clr),
`ifdef BCD_CNT_LOAD_EN
      .load     (load),
      .load_val (loadVal),
`endif
      .bcd3     (bcd3),
      .bcd2     (bcd2),
      .bcd1     (bcd1),
      .bcd0     (bcd0),
      .scan_sel (scanSel),
      .tick     (tick),
      .wrap     (wrap)
   );

   assign digits = {bcd3, bcd2, bcd1, bcd0};

   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   function automatic logic [15:0] toBcd(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, edgeCount);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic u, input logic c, input int cycles);
      en  = e;
      up  = u;
      clr = c;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic pushExp(input logic [15:0] d, input logic w, input int cyc);
      exp_t e;
      e.digits = d;
      e.wrap   = w;
      e.cyc    = cyc;
      sb.push_back(e);
   endtask

   // Monitor: every tick must match the oldest queued step in value, wrap flag and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (tick) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_tick: got digits %h wrap %b at cycle %0d, required no tick",
                     digits, wrap, edgeCount);
         end else begin
            e = sb.pop_front();
            if (digits !== e.digits || wrap !== e.wrap || edgeCount != e.cyc) begin
               bad++;
               $display("[TB] FAIL step: got digits %h wrap %b cycle %0d, required digits %h wrap %b cycle %0d",
                        digits, wrap, edgeCount, e.digits, e.wrap, e.cyc);
            end
         end
      end else begin
         if (sb.size() > 0 && edgeCount > sb[0].cyc) begin
            total++;
            bad++;
            e = sb.pop_front();
            $display("[TB] FAIL missing_tick: got no tick by cycle %0d, required digits %h wrap %b at cycle %0d",
                     edgeCount, e.digits, e.wrap, e.cyc);
         end
         if (wrap) begin
            total++;
            bad++;
            $display("[TB] FAIL wrap_without_tick: got wrap=1 tick=0 at cycle %0d, required wrap=0", edgeCount);
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got no completion by time %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int relEdge;
      int c0;
      int r2;
      logic [15:0] finalDigits;
`ifdef BCD_CNT_LOAD_EN
      int x;
      load    = 1'b0;
      loadVal = 16'h0000;
`endif
      rst_n = 1'b0;
      en    = 1'b0;
      up    = 1'b1;
      clr   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_digits", digits, 16'h0000);
      checkOutput("reset_flags", {14'd0, tick, wrap}, 16'h0000);
      checkOutput("reset_scan_sel", {14'd0, scanSel}, 16'h0000);

      // Idle after release: digits frozen, scan select walks 00,01,10,11 two cycles each.
      rst_n   = 1'b1;
      relEdge = edgeCount;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         checkOutput("scan_sel", {14'd0, scanSel}, 16'((n / 2) % 4));
      end
      checkOutput("idle_digits", digits, 16'h0000);

      // Count up 123 steps, one every 4 cycles.
      c0 = edgeCount;
      for (int n = 1; n <= 123; n++) pushExp(toBcd(n), 1'b0, c0 + 4 * n);
      applyStimulus(1'b1, 1'b1, 1'b0, 40);
      checkOutput("ten_steps", digits, 16'h0010);
      applyStimulus(1'b1, 1'b1, 1'b0, 455);
      checkOutput("at_0123", digits, 16'h0123);

      // clr on the step edge wins over the step.
      applyStimulus(1'b1, 1'b1, 1'b1, 1);
      checkOutput("clr_digits", digits, 16'h0000);
      checkOutput("clr_tick", {15'd0, tick}, 16'h0000);

      // Down through zero, then back up through 9999.
      pushExp(16'h9999, 1'b1, c0 + 500);
      pushExp(16'h9998, 1'b0, c0 + 504);
      applyStimulus(1'b1, 1'b0, 1'b0, 9);
      pushExp(16'h9999, 1'b0, c0 + 508);
      pushExp(16'h0000, 1'b1, c0 + 512);
      pushExp(16'h0001, 1'b0, c0 + 516);
      applyStimulus(1'b1, 1'b1, 1'b0, 13);
      checkOutput("pre_reset_digits", digits, 16'h0001);

      // Asynchronous reset mid-count.
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_digits", digits, 16'h0000);
      checkOutput("async_reset_flags", {14'd0, tick, wrap}, 16'h0000);
      checkOutput("async_reset_scan_sel", {14'd0, scanSel}, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r2    = edgeCount;
      pushExp(16'h0001, 1'b0, r2 + 4);
      applyStimulus(1'b1, 1'b1, 1'b0, 6);

`ifdef BCD_CNT_LOAD_EN
      load    = 1'b1;
      loadVal = 16'h12F9;
      x       = edgeCount;
      @(negedge clk);
      checkOutput("load_clamp", digits, 16'h1299);
      checkOutput("load_tick", {15'd0, tick}, 16'h0000);
      load = 1'b0;
      pushExp(16'h1300, 1'b0, x + 5);
      repeat (4) @(negedge clk);
      load    = 1'b1;
      loadVal = 16'h4567;
      applyStimulus(1'b1, 1'b1, 1'b1, 1);
      checkOutput("clr_over_load", digits, 16'h0000);
      load        = 1'b0;
      finalDigits = 16'h0000;
`else
      finalDigits = 16'h0001;
`endif

      applyStimulus(1'b0, 1'b1, 1'b0, 12);
      checkOutput("en_freeze", digits, finalDigits);
      checkOutput("scoreboard_empty", 16'(sb.size()), 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
